// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit for the MIPS_CPU execute stage.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        1-cycle request, sampled only while idle
//   op           0=mult 1=multu 2=div 3=divu
//   operand_a    rs: multiplicand / dividend / mthi-mtlo write data
//   operand_b    rt: multiplier / divisor
//   mthi, mtlo   write operand_a into HI / LO (idle only, start has priority)
//   busy         operation in flight
//   done         1-cycle pulse when HI/LO are updated or a divide by zero is reported
//   div_by_zero  qualifies done; held until the next start
//   hi, lo       HI/LO registers
//
// Build option: define MDU_FAST_MULT_EN to replace the iterative multiplier with a
// single-cycle combinational one (divide stays iterative).
module mult_div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              mthi,
  input  logic              mtlo,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                is_div_q;
  logic                dbz_q;
  logic                a_neg_q;
  logic                b_neg_q;
  logic [DATA_W-1:0]   ma_q;
  logic [DATA_W-1:0]   mb_q;
  // Shared datapath: multiply keeps {upper, multiplier/lower} here,
  // divide keeps {remainder, dividend/quotient}.
  logic [DATA_W-1:0]   p_hi;
  logic [DATA_W-1:0]   p_lo;

  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   ma;
  logic [DATA_W-1:0]   mb;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_sh;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_fix;

  // Signed ops work on magnitudes; the sign is restored in FIN.
  always_comb begin
    a_neg = ~op[0] & operand_a[DATA_W-1];
    b_neg = ~op[0] & operand_b[DATA_W-1];
    ma    = a_neg ? -operand_a : operand_a;
    mb    = b_neg ? -operand_b : operand_b;
  end

  always_comb begin
    mul_sum  = {1'b0, p_hi} + {1'b0, (p_lo[0] ? ma_q : '0)};
    div_sh   = {p_hi, p_lo[DATA_W-1]};
    div_ge   = div_sh >= {1'b0, mb_q};
    div_diff = div_sh - {1'b0, mb_q};
`ifdef MDU_FAST_MULT_EN
    prod     = {{DATA_W{1'b0}}, ma_q} * {{DATA_W{1'b0}}, mb_q};
`else
    prod     = {p_hi, p_lo};
`endif
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_div_q    <= 1'b0;
      dbz_q       <= 1'b0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            is_div_q    <= op[1];
            dbz_q       <= op[1] && (operand_b == '0);
            a_neg_q     <= a_neg;
            b_neg_q     <= b_neg;
            ma_q        <= ma;
            mb_q        <= mb;
            p_hi        <= '0;
            p_lo        <= op[1] ? ma : mb;
            if (op[1])
              state <= (operand_b == '0) ? S_FIN : S_DIV;
            else
`ifdef MDU_FAST_MULT_EN
              state <= S_FIN;
`else
              state <= S_MUL;
`endif
          end else begin
            if (mthi) hi <= operand_a;
            if (mtlo) lo <= operand_a;
          end
        end
        S_MUL: begin
          p_hi <= mul_sum[DATA_W:1];
          p_lo <= {mul_sum[0], p_lo[DATA_W-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= S_FIN;
        end
        S_DIV: begin
          p_hi <= div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0];
          p_lo <= {p_lo[DATA_W-2:0], div_ge};
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= S_FIN;
        end
        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
          if (dbz_q) begin
            div_by_zero <= 1'b1;
          end else if (is_div_q) begin
            lo <= (a_neg_q ^ b_neg_q) ? -p_lo : p_lo;
            hi <= a_neg_q ? -p_hi : p_hi;
          end else begin
            hi <= prod_fix[2*DATA_W-1:DATA_W];
            lo <= prod_fix[DATA_W-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
